// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage: FSM state encoding and
// register-file geometry.
package wb_pkg;

  localparam int NUM_REGS   = 8;
  localparam int REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    WRITE     = 2'd2
  } wb_state_e;

endpackage

// File: rtl/writeback_stage_if.sv
// Instruction hand-off from the execute/memory stage into writeback.
// Valid/ready: a transfer happens on a rising edge where in_valid and in_ready are
// both 1; the producer holds its fields stable while in_valid=1 and in_ready=0.
interface writeback_stage_if
  import wb_pkg::*;
#(
  parameter int D_SIZE = 32
);

  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] in_dest;
  logic [D_SIZE-1:0]     in_result;
  logic                  in_we;
  logic                  in_is_load;

  modport master (
    output in_valid, in_dest, in_result, in_we, in_is_load,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_dest, in_result, in_we, in_is_load,
    output in_ready
  );

endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: registers ALU results or waits for load data, then drives a
// single-cycle register-file write; tracks the busy register and write count.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int A_SIZE = 10,
  parameter int D_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  writeback_stage_if.slave      in_bus,
  input  logic                  mem_rvalid,
  input  logic [D_SIZE-1:0]     mem_rdata,
  output logic [REG_ADDR_W-1:0] dest_wb,
  output logic [D_SIZE-1:0]     result_wb,
  output logic                  write_en,
  output logic [NUM_REGS-1:0]   pending,
  output logic [15:0]           retired,
  output logic                  err_rvalid,
  output wb_state_e             state_dbg
);

  // Address width only keeps the parameter list uniform with sibling stages.
  localparam int unused_a_size = A_SIZE;

  wb_state_e             state, state_next;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [D_SIZE-1:0]     result_q;
  logic                  we_q;
  logic                  accept;

  assign accept = in_bus.in_valid & in_bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    in_bus.in_ready = 1'b0;
    unique case (state)
      IDLE, WRITE: begin
        in_bus.in_ready = 1'b1;
        if (accept && in_bus.in_is_load) begin
          state_next = WAIT_LOAD;
        end else if (accept && in_bus.in_we) begin
          state_next = WRITE;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          state_next = we_q ? WRITE : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture registers double as the register-file write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      dest_q     <= '0;
      result_q   <= '0;
      we_q       <= 1'b0;
      retired    <= '0;
      err_rvalid <= 1'b0;
    end else begin
      if (accept && in_bus.in_is_load) begin
        dest_q <= in_bus.in_dest;
        we_q   <= in_bus.in_we;
      end else if (accept && in_bus.in_we) begin
        dest_q   <= in_bus.in_dest;
        result_q <= in_bus.in_result;
        we_q     <= 1'b1;
      end
      if (state == WAIT_LOAD && mem_rvalid) begin
        result_q <= mem_rdata;
      end
      if (state == WRITE) begin
        retired <= retired + 16'd1;
      end
      // Read data with no outstanding load is a protocol violation.
      if (mem_rvalid && state != WAIT_LOAD) begin
        err_rvalid <= 1'b1;
      end
    end
  end

  always_comb begin
    pending = '0;
    if (state == WRITE || (state == WAIT_LOAD && we_q)) begin
      pending = NUM_REGS'(1) << dest_q;
    end
  end

  assign write_en  = (state == WRITE);
  assign dest_wb   = dest_q;
  assign result_wb = result_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: hand-computed expectations
// plus a write scoreboard fed by the driver tasks.
module tb_writeback_stage;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [2:0]  dest_wb;
  logic [31:0] result_wb;
  logic        write_en;
  logic [7:0]  pending;
  logic [15:0] retired;
  logic        err_rvalid;
  wb_state_e   state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [34:0] exp_q[$];

  writeback_stage_if #(.D_SIZE(32)) bus ();

  writeback_stage #(.A_SIZE(10), .D_SIZE(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_bus     (bus),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .dest_wb    (dest_wb),
    .result_wb  (result_wb),
    .write_en   (write_en),
    .pending    (pending),
    .retired    (retired),
    .err_rvalid (err_rvalid),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && write_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {29'd0, dest_wb, result_wb}, 64'd0);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        check("sb_dest", 64'(dest_wb), 64'(e[34:32]));
        check("sb_data", 64'(result_wb), 64'(e[31:0]));
      end
    end
  end

  // Driver tasks: each returns 1 time unit after the edge that consumed the drive.
  task automatic bus_idle();
    bus.in_valid   = 1'b0;
    bus.in_dest    = '0;
    bus.in_result  = '0;
    bus.in_we      = 1'b0;
    bus.in_is_load = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic [2:0] d, input logic [31:0] r, input logic we);
    bus.in_valid   = 1'b1;
    bus.in_dest    = d;
    bus.in_result  = r;
    bus.in_we      = we;
    bus.in_is_load = 1'b0;
    if (we) exp_q.push_back({d, r});
    step();
    bus_idle();
  endtask

  task automatic drive_load(input logic [2:0] d, input logic we);
    bus.in_valid   = 1'b1;
    bus.in_dest    = d;
    bus.in_result  = 32'h5555_AAAA;
    bus.in_we      = we;
    bus.in_is_load = 1'b1;
    step();
    bus_idle();
  endtask

  task automatic pulse_rvalid(input logic [31:0] data);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_we"},      64'(write_en),   64'd0);
    check({tag, "_dest"},    64'(dest_wb),    64'd0);
    check({tag, "_result"},  64'(result_wb),  64'd0);
    check({tag, "_pending"}, 64'(pending),    64'd0);
    check({tag, "_retired"}, 64'(retired),    64'd0);
    check({tag, "_err"},     64'(err_rvalid), 64'd0);
    check({tag, "_ready"},   64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    bus_idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_reset_state("rst");

    // Single ALU write to r3
    drive_alu(3'd3, 32'h0000_00A5, 1'b1);
    check("alu_we",      64'(write_en),  64'd1);
    check("alu_dest",    64'(dest_wb),   64'd3);
    check("alu_result",  64'(result_wb), 64'h0000_00A5);
    check("alu_pending", 64'(pending),   64'h08);
    step();
    check("alu_retired", 64'(retired),   64'd1);
    check("alu_done_we", 64'(write_en),  64'd0);

    // Back-to-back ALU writes, one per cycle
    for (int i = 1; i <= 3; i++) begin
      drive_alu(3'(i), 32'h1000_0000 + 32'(i), 1'b1);
      check("b2b_we",   64'(write_en), 64'd1);
      check("b2b_dest", 64'(dest_wb),  64'(i));
    end
    step();
    check("b2b_retired", 64'(retired),  64'd4);
    check("b2b_idle_we", 64'(write_en), 64'd0);

    // Bubble: accepted but no write
    drive_alu(3'd6, 32'hFFFF_FFFF, 1'b0);
    check("bubble_we",    64'(write_en),  64'd0);
    check("bubble_state", 64'(state_dbg), 64'(IDLE));
    check("bubble_pend",  64'(pending),   64'd0);

    // Load to r5 with rvalid after 4 wait cycles; a held request must not be taken
    drive_load(3'd5, 1'b1);
    bus.in_valid  = 1'b1;
    bus.in_dest   = 3'd7;
    bus.in_result = 32'h7777_7777;
    bus.in_we     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("load_ready",   64'(bus.in_ready), 64'd0);
      check("load_pending", 64'(pending),      64'h20);
      check("load_wait_we", 64'(write_en),     64'd0);
      step();
    end
    bus_idle();
    exp_q.push_back({3'd5, 32'hDEAD_BEEF});
    pulse_rvalid(32'hDEAD_BEEF);
    check("load_we",      64'(write_en),  64'd1);
    check("load_dest",    64'(dest_wb),   64'd5);
    check("load_result",  64'(result_wb), 64'hDEAD_BEEF);
    check("load_wr_pend", 64'(pending),   64'h20);
    step();
    check("load_retired", 64'(retired),   64'd5);
    check("load_err",     64'(err_rvalid), 64'd0);

    // Load with we=0: data discarded
    drive_load(3'd6, 1'b0);
    check("nowe_state", 64'(state_dbg), 64'(WAIT_LOAD));
    check("nowe_pend",  64'(pending),   64'd0);
    pulse_rvalid(32'h0BAD_F00D);
    check("nowe_we",      64'(write_en),  64'd0);
    check("nowe_state2",  64'(state_dbg), 64'(IDLE));
    check("nowe_retired", 64'(retired),   64'd5);

    // Register 0 is an ordinary destination
    drive_alu(3'd0, 32'h0000_1234, 1'b1);
    check("r0_we",      64'(write_en), 64'd1);
    check("r0_pending", 64'(pending),  64'h01);
    step();
    check("r0_retired", 64'(retired),  64'd6);

    // Stray rvalid in IDLE: sticky error, data ignored
    pulse_rvalid(32'hCAFE_CAFE);
    check("stray_err",    64'(err_rvalid), 64'd1);
    check("stray_we",     64'(write_en),   64'd0);
    check("stray_result", 64'(result_wb),  64'h0000_1234);
    step();
    step();
    check("stray_sticky", 64'(err_rvalid), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_state("rst2");

    // Reset while waiting for a load; inputs presented during reset are ignored
    drive_load(3'd2, 1'b1);
    check("rstld_pend", 64'(pending), 64'h04);
    reset = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_dest    = 3'd4;
    bus.in_result  = 32'h4444_4444;
    bus.in_we      = 1'b1;
    bus.in_is_load = 1'b0;
    mem_rvalid     = 1'b1;
    mem_rdata      = 32'h9999_9999;
    step();
    reset = 1'b0;
    bus_idle();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    check_reset_state("rst3");
    check("rstld_state", 64'(state_dbg), 64'(IDLE));
    pulse_rvalid(32'h1111_2222);
    check("rstld_we",   64'(write_en),   64'd0);
    check("rstld_pend2", 64'(pending),   64'd0);
    check("rstld_err",  64'(err_rvalid), 64'd1);
    step();
    check("rstld_retired", 64'(retired), 64'd0);

    step();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
